// File: rtl/axis_width_adapter.sv
`default_nettype none
// ============================================================================
// Module      : axis_width_adapter
// Description : AXI4-Stream lane-width converter (pass-through, upsize, or
//               downsize). The optional parameter sanity check is enabled by
//               defining AXIS_WIDTH_ADAPTER_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_width_adapter #(
    parameter int S_DATA_WIDTH  = 8,
    parameter int S_KEEP_ENABLE = (S_DATA_WIDTH > 8),
    parameter int S_KEEP_WIDTH  = (S_DATA_WIDTH + 7) / 8,
    parameter int M_DATA_WIDTH  = 8,
    parameter int M_KEEP_ENABLE = (M_DATA_WIDTH > 8),
    parameter int M_KEEP_WIDTH  = (M_DATA_WIDTH + 7) / 8,
    parameter int ID_ENABLE     = 0,
    parameter int ID_WIDTH      = 8,
    parameter int DEST_ENABLE   = 0,
    parameter int DEST_WIDTH    = 8,
    parameter int USER_ENABLE   = 1,
    parameter int USER_WIDTH    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    s_axis_tlast,
    input  logic [ID_WIDTH-1:0]     s_axis_tid,
    input  logic [DEST_WIDTH-1:0]   s_axis_tdest,
    input  logic [USER_WIDTH-1:0]   s_axis_tuser,
    output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
    output logic [M_KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [ID_WIDTH-1:0]     m_axis_tid,
    output logic [DEST_WIDTH-1:0]   m_axis_tdest,
    output logic [USER_WIDTH-1:0]   m_axis_tuser
);
    localparam int c_S_K   = (S_KEEP_ENABLE != 0) ? S_KEEP_WIDTH : 1;
    localparam int c_M_K   = (M_KEEP_ENABLE != 0) ? M_KEEP_WIDTH : 1;
    localparam int c_SEG   = (c_M_K > c_S_K) ? c_M_K / c_S_K : c_S_K / c_M_K;
    localparam int c_CNT_W = (c_SEG > 1) ? $clog2(c_SEG) : 1;

`ifdef AXIS_WIDTH_ADAPTER_CHECK_EN
    initial begin
        if ((S_DATA_WIDTH % c_S_K) != 0 || (M_DATA_WIDTH % c_M_K) != 0 ||
            (S_DATA_WIDTH / c_S_K) != (M_DATA_WIDTH / c_M_K) ||
            (((c_M_K > c_S_K) ? (c_M_K % c_S_K) : (c_S_K % c_M_K)) != 0)) begin
            $error("%m: illegal lane configuration for axis_width_adapter");
            $finish;
        end
    end
`endif

    logic [c_S_K-1:0] w_s_keep;
    logic [c_M_K-1:0] w_m_keep;
    logic             w_unused_keep;

    // A disabled input keep behaves as a single always-valid lane.
    assign w_s_keep      = (S_KEEP_ENABLE != 0) ? s_axis_tkeep[c_S_K-1:0] : '1;
    assign w_unused_keep = ^s_axis_tkeep;

    generate
        if (M_KEEP_ENABLE != 0) begin : g_m_keep
            assign m_axis_tkeep = w_m_keep;
        end else begin : g_m_keep_ones
            logic w_unused_m_keep;
            assign w_unused_m_keep = ^w_m_keep;
            assign m_axis_tkeep    = '1;
        end

        if (c_S_K == c_M_K) begin : g_passthrough
            assign m_axis_tdata  = s_axis_tdata;
            assign w_m_keep      = w_s_keep;
            assign m_axis_tvalid = s_axis_tvalid;
            assign s_axis_tready = m_axis_tready;
            assign m_axis_tlast  = s_axis_tlast;
            assign m_axis_tid    = (ID_ENABLE != 0)   ? s_axis_tid   : '0;
            assign m_axis_tdest  = (DEST_ENABLE != 0) ? s_axis_tdest : '0;
            assign m_axis_tuser  = (USER_ENABLE != 0) ? s_axis_tuser : '0;
        end else if (c_M_K > c_S_K) begin : g_upsize
            logic [M_DATA_WIDTH-1:0] r_data;
            logic [M_DATA_WIDTH-1:0] w_data_nxt;
            logic [c_M_K-1:0]        r_keep;
            logic [c_M_K-1:0]        w_keep_nxt;
            logic                    r_valid;
            logic                    r_last;
            logic [ID_WIDTH-1:0]     r_id;
            logic [DEST_WIDTH-1:0]   r_dest;
            logic [USER_WIDTH-1:0]   r_user;
            logic [c_CNT_W-1:0]      r_cnt;
            logic                    w_s_fire;
            logic                    w_m_fire;
            logic                    w_beat_done;

            assign s_axis_tready = !r_valid || m_axis_tready;
            assign w_s_fire      = s_axis_tvalid && s_axis_tready;
            assign w_m_fire      = r_valid && m_axis_tready;
            assign w_beat_done   = s_axis_tlast || (r_cnt == c_CNT_W'(c_SEG - 1));

            // Segment 0 starts a fresh beat so unfilled segments read as zero.
            always_comb begin
                w_data_nxt = (r_cnt == '0) ? '0 : r_data;
                w_keep_nxt = (r_cnt == '0) ? '0 : r_keep;
                w_data_nxt[r_cnt*S_DATA_WIDTH +: S_DATA_WIDTH] = s_axis_tdata;
                w_keep_nxt[r_cnt*c_S_K +: c_S_K]               = w_s_keep;
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_data  <= '0;
                    r_keep  <= '0;
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_id    <= '0;
                    r_dest  <= '0;
                    r_user  <= '0;
                    r_cnt   <= '0;
                end else begin
                    if (w_m_fire) begin
                        r_valid <= 1'b0;
                    end
                    if (w_s_fire) begin
                        r_data <= w_data_nxt;
                        r_keep <= w_keep_nxt;
                        r_last <= s_axis_tlast;
                        r_user <= s_axis_tuser;
                        if (r_cnt == '0) begin
                            r_id   <= s_axis_tid;
                            r_dest <= s_axis_tdest;
                        end
                        if (w_beat_done) begin
                            r_valid <= 1'b1;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_CNT_W'(1);
                        end
                    end
                end
            end

            assign m_axis_tdata  = r_data;
            assign w_m_keep      = r_keep;
            assign m_axis_tvalid = r_valid;
            assign m_axis_tlast  = r_last;
            assign m_axis_tid    = (ID_ENABLE != 0)   ? r_id   : '0;
            assign m_axis_tdest  = (DEST_ENABLE != 0) ? r_dest : '0;
            assign m_axis_tuser  = (USER_ENABLE != 0) ? r_user : '0;
        end else begin : g_downsize
            logic [S_DATA_WIDTH-1:0] r_data;
            logic [c_S_K-1:0]        r_keep;
            logic                    r_valid;
            logic                    r_last;
            logic [ID_WIDTH-1:0]     r_id;
            logic [DEST_WIDTH-1:0]   r_dest;
            logic [USER_WIDTH-1:0]   r_user;
            logic [c_CNT_W-1:0]      r_cnt;
            logic [c_CNT_W-1:0]      r_last_seg;
            logic [c_CNT_W-1:0]      w_hi_seg;
            logic                    w_final;
            logic                    w_s_fire;

            // Highest segment holding any valid lane; 0 when keep is empty.
            always_comb begin
                w_hi_seg = '0;
                for (int i = 1; i < c_SEG; i++) begin
                    if (|w_s_keep[i*c_M_K +: c_M_K]) begin
                        w_hi_seg = c_CNT_W'(i);
                    end
                end
            end

            assign w_final       = (r_cnt == (r_last ? r_last_seg : c_CNT_W'(c_SEG - 1)));
            assign s_axis_tready = !r_valid || (m_axis_tready && w_final);
            assign w_s_fire      = s_axis_tvalid && s_axis_tready;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_data     <= '0;
                    r_keep     <= '0;
                    r_valid    <= 1'b0;
                    r_last     <= 1'b0;
                    r_id       <= '0;
                    r_dest     <= '0;
                    r_user     <= '0;
                    r_cnt      <= '0;
                    r_last_seg <= '0;
                end else if (w_s_fire) begin
                    r_data     <= s_axis_tdata;
                    r_keep     <= w_s_keep;
                    r_valid    <= 1'b1;
                    r_last     <= s_axis_tlast;
                    r_id       <= s_axis_tid;
                    r_dest     <= s_axis_tdest;
                    r_user     <= s_axis_tuser;
                    r_cnt      <= '0;
                    r_last_seg <= w_hi_seg;
                end else if (r_valid && m_axis_tready) begin
                    if (w_final) begin
                        r_valid <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
            end

            assign m_axis_tdata  = r_data[r_cnt*M_DATA_WIDTH +: M_DATA_WIDTH];
            assign w_m_keep      = r_keep[r_cnt*c_M_K +: c_M_K];
            assign m_axis_tvalid = r_valid;
            assign m_axis_tlast  = r_last && w_final;
            assign m_axis_tid    = (ID_ENABLE != 0)   ? r_id   : '0;
            assign m_axis_tdest  = (DEST_ENABLE != 0) ? r_dest : '0;
            assign m_axis_tuser  = (USER_ENABLE != 0) ? r_user : '0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axis_width_adapter.sv
`default_nettype none
// Testbench for axis_width_adapter: pass-through 8->8, upsize 8->32 and
// downsize 32->8 instances against a queue-based reference model.
module tb_axis_width_adapter;

    typedef struct packed {
        logic [7:0] data; logic last; logic [7:0] id; logic [7:0] dest; logic user;
    } up_in_t;
    typedef struct packed {
        logic [31:0] data; logic [3:0] keep; logic last; logic [7:0] id; logic [7:0] dest; logic user;
    } up_out_t;
    typedef struct packed {
        logic [31:0] data; logic [3:0] keep; logic last; logic [7:0] id; logic [7:0] dest; logic user;
    } dn_in_t;
    typedef struct packed {
        logic [7:0] data; logic last; logic [7:0] id; logic [7:0] dest; logic user;
    } dn_out_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // pass-through 8 -> 8
    logic [7:0] p_s_data, p_m_data, p_s_id, p_s_dest, p_m_id, p_m_dest;
    logic       p_s_keep, p_m_keep, p_s_valid, p_s_ready, p_s_last, p_s_user;
    logic       p_m_valid, p_m_ready, p_m_last, p_m_user;
    // upsize 8 -> 32
    logic [7:0]  u_s_data, u_s_id, u_s_dest, u_m_id, u_m_dest;
    logic        u_s_keep, u_s_valid, u_s_ready, u_s_last, u_s_user;
    logic [31:0] u_m_data;
    logic [3:0]  u_m_keep;
    logic        u_m_valid, u_m_ready, u_m_last, u_m_user;
    // downsize 32 -> 8
    logic [31:0] d_s_data;
    logic [3:0]  d_s_keep;
    logic [7:0]  d_s_id, d_s_dest, d_m_data, d_m_id, d_m_dest;
    logic        d_s_valid, d_s_ready, d_s_last, d_s_user;
    logic        d_m_keep, d_m_valid, d_m_ready, d_m_last, d_m_user;

    axis_width_adapter u_pt (
        .clk(clk), .rst(rst),
        .s_axis_tdata(p_s_data), .s_axis_tkeep(p_s_keep), .s_axis_tvalid(p_s_valid),
        .s_axis_tready(p_s_ready), .s_axis_tlast(p_s_last), .s_axis_tid(p_s_id),
        .s_axis_tdest(p_s_dest), .s_axis_tuser(p_s_user),
        .m_axis_tdata(p_m_data), .m_axis_tkeep(p_m_keep), .m_axis_tvalid(p_m_valid),
        .m_axis_tready(p_m_ready), .m_axis_tlast(p_m_last), .m_axis_tid(p_m_id),
        .m_axis_tdest(p_m_dest), .m_axis_tuser(p_m_user)
    );

    axis_width_adapter #(.S_DATA_WIDTH(8), .M_DATA_WIDTH(32), .ID_ENABLE(1), .DEST_ENABLE(1)) u_up (
        .clk(clk), .rst(rst),
        .s_axis_tdata(u_s_data), .s_axis_tkeep(u_s_keep), .s_axis_tvalid(u_s_valid),
        .s_axis_tready(u_s_ready), .s_axis_tlast(u_s_last), .s_axis_tid(u_s_id),
        .s_axis_tdest(u_s_dest), .s_axis_tuser(u_s_user),
        .m_axis_tdata(u_m_data), .m_axis_tkeep(u_m_keep), .m_axis_tvalid(u_m_valid),
        .m_axis_tready(u_m_ready), .m_axis_tlast(u_m_last), .m_axis_tid(u_m_id),
        .m_axis_tdest(u_m_dest), .m_axis_tuser(u_m_user)
    );

    axis_width_adapter #(.S_DATA_WIDTH(32), .M_DATA_WIDTH(8), .ID_ENABLE(1), .DEST_ENABLE(1)) u_dn (
        .clk(clk), .rst(rst),
        .s_axis_tdata(d_s_data), .s_axis_tkeep(d_s_keep), .s_axis_tvalid(d_s_valid),
        .s_axis_tready(d_s_ready), .s_axis_tlast(d_s_last), .s_axis_tid(d_s_id),
        .s_axis_tdest(d_s_dest), .s_axis_tuser(d_s_user),
        .m_axis_tdata(d_m_data), .m_axis_tkeep(d_m_keep), .m_axis_tvalid(d_m_valid),
        .m_axis_tready(d_m_ready), .m_axis_tlast(d_m_last), .m_axis_tid(d_m_id),
        .m_axis_tdest(d_m_dest), .m_axis_tuser(d_m_user)
    );

    up_in_t  uq_in[$];
    up_out_t uq_exp[$];
    dn_in_t  dq_in[$];
    dn_out_t dq_exp[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference: bytes group four at a time, LSB first; a tlast closes a short beat.
    task automatic up_frame(input int len, input bit last, input bit seq);
        up_in_t  b[$];
        up_in_t  it;
        up_out_t o;
        int      n;
        for (int i = 0; i < len; i++) begin
            it.data = seq ? 8'(8'h11 * (i + 1)) : 8'($urandom);
            it.last = last && (i == len - 1);
            it.id   = 8'($urandom);
            it.dest = 8'($urandom);
            it.user = 1'($urandom);
            b.push_back(it);
            uq_in.push_back(it);
        end
        for (int g = 0; g < len; g += 4) begin
            n = (len - g < 4) ? len - g : 4;
            o = '0;
            for (int k = 0; k < n; k++) begin
                o.data[8*k +: 8] = b[g+k].data;
                o.keep[k]        = 1'b1;
            end
            o.last = last && (g + n == len);
            o.id   = b[g].id;
            o.dest = b[g].dest;
            o.user = b[g+n-1].user;
            uq_exp.push_back(o);
        end
    endtask

    // Reference: a wide beat yields four bytes, or up to its highest kept byte when last.
    task automatic dn_beat(input logic [31:0] data, input logic [3:0] keep, input bit last);
        dn_in_t  b;
        dn_out_t o;
        int      nseg;
        b.data = data; b.keep = keep; b.last = last;
        b.id = 8'($urandom); b.dest = 8'($urandom); b.user = 1'($urandom);
        dq_in.push_back(b);
        nseg = 4;
        if (last) begin
            nseg = 1;
            for (int k = 0; k < 4; k++) if (keep[k]) nseg = k + 1;
        end
        for (int k = 0; k < nseg; k++) begin
            o.data = data[8*k +: 8];
            o.last = last && (k == nseg - 1);
            o.id = b.id; o.dest = b.dest; o.user = b.user;
            dq_exp.push_back(o);
        end
    endtask

    // mode 0: always ready, 1: random ready and valid gaps, 2: ready toggles 1010
    task automatic run_up(input int mode);
        int      cyc = 0;
        int      stalls = 0;
        bit      pend = 0;
        bit      hold = 0;
        up_out_t cur, held;
        while ((uq_in.size() != 0 || uq_exp.size() != 0) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            u_s_valid = (uq_in.size() != 0) && (pend || mode != 1 || $urandom_range(0, 3) != 0);
            if (u_s_valid) {u_s_data, u_s_last, u_s_id, u_s_dest, u_s_user} = uq_in[0];
            u_m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'(cyc % 2);
            #1;
            cur = {u_m_data, u_m_keep, u_m_last, u_m_id, u_m_dest, u_m_user};
            if (hold) check("up_hold", {u_m_valid, cur}, {1'b1, held});
            hold = u_m_valid && !u_m_ready;
            held = cur;
            pend = u_s_valid && !u_s_ready;
            if (pend && mode == 0) stalls++;
            if (u_s_valid && u_s_ready) void'(uq_in.pop_front());
            if (u_m_valid && u_m_ready) begin
                if (uq_exp.size() == 0) check("up_extra", 64'(uq_exp.size()), 64'd1);
                else check("up_beat", cur, uq_exp.pop_front());
            end
        end
        @(negedge clk);
        u_s_valid = 1'b0;
        check("up_done", 64'(uq_in.size() + uq_exp.size()), 64'd0);
        if (mode == 0) check("up_stalls", 64'(stalls), 64'd0);
    endtask

    task automatic run_dn(input int mode);
        int      cyc = 0;
        int      gaps = 0;
        bit      started = 0;
        bit      pend = 0;
        bit      hold = 0;
        dn_out_t cur, held;
        while ((dq_in.size() != 0 || dq_exp.size() != 0) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            d_s_valid = (dq_in.size() != 0) && (pend || mode != 1 || $urandom_range(0, 3) != 0);
            if (d_s_valid) {d_s_data, d_s_keep, d_s_last, d_s_id, d_s_dest, d_s_user} = dq_in[0];
            d_m_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'(cyc % 2);
            #1;
            cur = {d_m_data, d_m_last, d_m_id, d_m_dest, d_m_user};
            if (hold) check("dn_hold", {d_m_valid, cur}, {1'b1, held});
            hold = d_m_valid && !d_m_ready;
            held = cur;
            pend = d_s_valid && !d_s_ready;
            if (d_m_valid) started = 1;
            else if (started && dq_exp.size() != 0 && mode == 0) gaps++;
            if (d_s_valid && d_s_ready) void'(dq_in.pop_front());
            if (d_m_valid && d_m_ready) begin
                if (dq_exp.size() == 0) check("dn_extra", 64'(dq_exp.size()), 64'd1);
                else begin
                    check("dn_beat", cur, dq_exp.pop_front());
                    check("dn_keep", d_m_keep, 1'b1);
                end
            end
        end
        @(negedge clk);
        d_s_valid = 1'b0;
        check("dn_done", 64'(dq_in.size() + dq_exp.size()), 64'd0);
        if (mode == 0) check("dn_gaps", 64'(gaps), 64'd0);
    endtask

    initial begin
        logic [7:0] pt[3];
        up_in_t     it;
        pt = '{8'hAA, 8'hBB, 8'hCC};
        rst = 1'b1;
        {p_s_data, p_s_valid, p_s_last, p_s_id, p_s_dest, p_s_user, p_m_ready} = '0;
        p_s_keep = 1'b1;
        {u_s_data, u_s_valid, u_s_last, u_s_id, u_s_dest, u_s_user, u_m_ready} = '0;
        u_s_keep = 1'b1;
        {d_s_data, d_s_keep, d_s_valid, d_s_last, d_s_id, d_s_dest, d_s_user, d_m_ready} = '0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_up_valid", u_m_valid, 1'b0);
        check("rst_up_regs", {u_m_data, u_m_keep, u_m_last, u_m_id, u_m_dest, u_m_user}, 64'd0);
        check("rst_up_ready", u_s_ready, 1'b1);
        check("rst_dn_valid", d_m_valid, 1'b0);
        check("rst_dn_regs", {d_m_data, d_m_last, d_m_id, d_m_dest, d_m_user}, 64'd0);
        check("rst_dn_ready", d_s_ready, 1'b1);
        rst = 1'b0;

        // pass-through: same-cycle data, tready straight through, sidebands zeroed
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            p_s_valid = 1'b1;
            p_s_data  = pt[i];
            p_s_last  = (i == 2);
            p_s_id    = 8'h5A;
            p_s_dest  = 8'hC3;
            p_s_user  = 1'(i % 2);
            p_m_ready = (i != 1);
            #1;
            check("pt_data", {p_m_valid, p_m_data, p_m_last, p_m_keep, p_m_user},
                  {1'b1, pt[i], 1'(i == 2), 1'b1, 1'(i % 2)});
            check("pt_ready", p_s_ready, p_m_ready);
            check("pt_sideband", {p_m_id, p_m_dest}, 16'h0);
        end
        @(negedge clk);
        p_s_valid = 1'b0;

        // upsize directed: 01..05 last on 05, tid 3
        for (int i = 0; i < 5; i++) begin
            it.data = 8'(i + 1); it.last = (i == 4); it.id = 8'd3; it.dest = 8'd0; it.user = 1'b0;
            uq_in.push_back(it);
        end
        uq_exp.push_back({32'h04030201, 4'hF, 1'b0, 8'd3, 8'd0, 1'b0});
        uq_exp.push_back({32'h00000005, 4'h1, 1'b1, 8'd3, 8'd0, 1'b0});
        run_up(0);

        // upsize random frames under back-pressure
        for (int f = 0; f < 6; f++) up_frame($urandom_range(1, 9), 1'b1, 1'b0);
        run_up(1);
        for (int f = 0; f < 3; f++) up_frame($urandom_range(1, 9), 1'b1, 1'b0);
        run_up(2);
        for (int f = 0; f < 3; f++) up_frame(4 * $urandom_range(1, 2), 1'b1, 1'b0);
        run_up(0);

        // upsize reset mid-frame
        @(negedge clk);
        u_m_ready = 1'b1;
        u_s_valid = 1'b1;
        u_s_last  = 1'b0;
        u_s_data  = 8'hE1;
        @(negedge clk);
        u_s_data  = 8'hE2;
        @(negedge clk);
        u_s_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_valid", u_m_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_after", {u_m_valid, u_s_ready}, 2'b01);
        up_frame(4, 1'b0, 1'b1);
        check("midrst_model", {uq_exp[0].data, uq_exp[0].keep}, {32'h44332211, 4'hF});
        run_up(0);

        // downsize directed boundaries
        dn_beat(32'h44332211, 4'hF, 1'b1);
        dn_beat(32'h00002211, 4'h3, 1'b1);
        dn_beat(32'h00002211, 4'h3, 1'b0);
        dn_beat(32'h000000A5, 4'h0, 1'b1);
        dn_beat(32'h00330000, 4'h4, 1'b1);
        run_dn(0);

        // downsize random beats: 1010 ready, random ready, then back-to-back non-last
        for (int b = 0; b < 6; b++) dn_beat($urandom, 4'($urandom), 1'($urandom));
        run_dn(2);
        for (int b = 0; b < 8; b++) dn_beat($urandom, 4'($urandom), 1'($urandom));
        run_dn(1);
        for (int b = 0; b < 3; b++) dn_beat($urandom, 4'($urandom), 1'b0);
        run_dn(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
